cycle_seq: RTL and testbench
============================

CYCLE_SEQ -- requirements
Module: cycle_seq

Interface
- REQ-001 Parameter RESET_CYCLES, default 7, is the number of cycles spent in the post-reset sequence before the first opcode fetch; legal range 1..15.
- REQ-002 Parameter MAX_T, default 7, is the highest legal T-state index; legal range 2..7.
- REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
- REQ-004 Port rst  input  1  asynchronous, active-high reset.
- REQ-005 Port rdy  input  1  1 = advance, 0 = stall (hold all state).
- REQ-006 Port last_cycle  input  1  decoder flag: the current T-state is the instruction's final cycle.
- REQ-007 Port nmi_n  input  1  active-low NMI pin, falling-edge sensitive.
- REQ-008 Port irq_n  input  1  active-low IRQ pin, level sensitive.
- REQ-009 Port i_flag  input  1  processor-status I bit; 1 masks IRQ.
- REQ-010 Port sync  output  1  high during the opcode-fetch cycle (T0); drives the IR latch enable.
- REQ-011 Port t_state  output  3  current T-state index; 0 = fetch.
- REQ-012 Port ir_load  output  1  sync AND rdy; IR captures the data bus this cycle.
- REQ-013 Port pc_inc  output  1  PC increment request on fetch.
- REQ-014 Port int_inject  output  1  IR loads the BRK opcode (8'h00) instead of the bus for this fetch.
- REQ-015 Port nmi_sel  output  1  valid with int_inject; 1 = NMI vector, 0 = IRQ vector.
- REQ-016 Port seq_err  output  1  one-cycle pulse on forced T-state overflow.

Function
- REQ-017 The state machine SHALL have three states: RSTSEQ, FETCH, EXEC.
- REQ-018 RSTSEQ SHALL count 0..RESET_CYCLES-1 on rdy cycles, then go to FETCH; sync=0, t_state=0 throughout.
- REQ-019 FETCH SHALL drive sync=1 and t_state=0; on rdy it SHALL go to EXEC with t_state=1.
- REQ-020 pc_inc SHALL equal ir_load AND NOT int_inject.
- REQ-021 EXEC SHALL increment t_state on each rdy cycle; when last_cycle=1 and rdy=1 it SHALL go to FETCH.
- REQ-022 If t_state=MAX_T and rdy=1 with last_cycle=0, the block SHALL go to FETCH and pulse seq_err for one cycle.
- REQ-023 When rdy=0 the state, t_state, and pending interrupts SHALL hold; sync SHALL stay high in a stalled FETCH; ir_load and pc_inc SHALL be 0.
- REQ-024 A falling edge of nmi_n SHALL set an NMI-pending latch; the latch SHALL clear on the fetch that injects it.
- REQ-025 IRQ SHALL be pending while irq_n=0 and i_flag=0, sampled at the FETCH cycle.
- REQ-026 In FETCH, int_inject SHALL be 1 if NMI or IRQ is pending; NMI SHALL win when both are pending (nmi_sel=1).
- REQ-027 int_inject and nmi_sel SHALL be 0 outside FETCH.
- REQ-028 An NMI edge arriving in the same cycle as the FETCH that injects it SHALL remain latched for the next fetch and SHALL NOT be lost.

Reset
- REQ-029 rst=1 SHALL immediately force RSTSEQ: counter=0, sync=0, t_state=0, ir_load=0, pc_inc=0, int_inject=0, nmi_sel=0, seq_err=0, NMI latch cleared.
- REQ-030 rst asserted mid-instruction SHALL abort the instruction; the full RESET_CYCLES sequence SHALL restart after deassertion.
- REQ-031 After rst deasserts, the nmi_n edge detector SHALL treat the previous pin value as 1.

Configuration
- REQ-032 With macro CYCLE_SEQ_INT_EN defined, the interrupt logic of REQ-024..REQ-028 SHALL be built.
- REQ-033 Without CYCLE_SEQ_INT_EN, int_inject and nmi_sel SHALL be tied 0, and nmi_n, irq_n, and i_flag SHALL be ignored.

Structure
- REQ-034 Shared package cpu_pkg SHALL hold the state encoding (RSTSEQ/FETCH/EXEC), OPC_BRK=8'h00, and T_W=3.
- REQ-035 NMI edge detection, the NMI latch, and IRQ qualification SHALL live in sub-module int_ctl, instantiated only under CYCLE_SEQ_INT_EN.

Verification
- REQ-036 Reset with RESET_CYCLES=7 and rdy=1: first sync=1 exactly 7 cycles after rst falls; t_state then runs 0,1,2 when last_cycle=1 at T2.
- REQ-037 rdy=0 for 3 cycles during FETCH: sync holds 1, ir_load=0 for those 3 cycles, t_state=0; the advance to t_state=1 occurs one cycle after rdy=1.
- REQ-038 last_cycle held 0 with MAX_T=7: t_state reaches 7, then FETCH follows with one seq_err pulse.
- REQ-039 nmi_n 1->0 during EXEC with irq_n=0 and i_flag=0: next FETCH gives int_inject=1, nmi_sel=1, pc_inc=0; the following FETCH gives int_inject=1, nmi_sel=0.
- REQ-040 irq_n=0 with i_flag=1: no injection; rst pulse at t_state=3: sync=0 and t_state=0 immediately, with the 7-cycle sequence repeated.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU cycle sequencer: FSM states, T-state width, BRK opcode.
// Latency: none (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int         T_W       = 3;
    localparam int         RST_CNT_W = 4;
    localparam logic [7:0] OPC_BRK   = 8'h00;

    typedef enum logic [1:0] {
        RSTSEQ = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/cycle_seq_if.sv
// Sequencer bus: decoder/pin inputs toward the sequencer, fetch/T-state controls back out.
// Latency: none (wiring only).
// Backpressure: rdy carried here; slave is the sequencer, master is whoever drives the pins.
interface cycle_seq_if;
    import cpu_pkg::*;

    logic           rdy;
    logic           last_cycle;
    logic           nmi_n;
    logic           irq_n;
    logic           i_flag;
    logic           sync;
    logic [T_W-1:0] t_state;
    logic           ir_load;
    logic           pc_inc;
    logic           int_inject;
    logic           nmi_sel;
    logic           seq_err;

    modport master (
        output rdy, last_cycle, nmi_n, irq_n, i_flag,
        input  sync, t_state, ir_load, pc_inc, int_inject, nmi_sel, seq_err
    );

    modport slave (
        input  rdy, last_cycle, nmi_n, irq_n, i_flag,
        output sync, t_state, ir_load, pc_inc, int_inject, nmi_sel, seq_err
    );
endinterface

// File: rtl/int_ctl.sv
// NMI falling-edge latch and IRQ qualification; only compiled with CYCLE_SEQ_INT_EN.
// Latency: NMI pending one cycle after the pin edge; IRQ pending is combinational.
// Backpressure: latch clears only on a fetch with rdy=1, so stalls keep it pending.
`ifdef CYCLE_SEQ_INT_EN
module int_ctl (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic fetch,
    input  logic nmi_n,
    input  logic irq_n,
    input  logic i_flag,
    output logic nmi_pend,
    output logic irq_pend
);
    logic nmi_prev_q, nmi_prev_d;
    logic nmi_lat_q,  nmi_lat_d;

    // Clear before set: an edge landing on the consuming fetch re-arms the latch.
    always_comb begin
        nmi_prev_d = nmi_n;
        nmi_lat_d  = nmi_lat_q;
        if (fetch && rdy) begin
            nmi_lat_d = 1'b0;
        end
        if (nmi_prev_q && !nmi_n) begin
            nmi_lat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_prev_q <= 1'b1;
            nmi_lat_q  <= 1'b0;
        end else begin
            nmi_prev_q <= nmi_prev_d;
            nmi_lat_q  <= nmi_lat_d;
        end
    end

    assign nmi_pend = nmi_lat_q;
    assign irq_pend = !irq_n && !i_flag;
endmodule
`endif

// File: rtl/cycle_seq.sv
// CPU T-state sequencer: reset sequence, opcode fetch, execute steps, overflow trap; CYCLE_SEQ_INT_EN adds NMI/IRQ BRK injection.
// Latency: state, t_state, sync, seq_err registered; ir_load/pc_inc/int_inject follow rdy and pins combinationally.
// Backpressure: rdy=0 freezes all state; sync holds in FETCH while ir_load and pc_inc drop to 0.
module cycle_seq
    import cpu_pkg::*;
#(
    parameter int RESET_CYCLES = 7,
    parameter int MAX_T        = 7
) (
    input  logic       clk,
    input  logic       rst,
    cycle_seq_if.slave bus
);
    localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);
    localparam logic [T_W-1:0]       T_LAST   = T_W'(MAX_T);

    seq_state_e           state_q, state_d;
    logic [RST_CNT_W-1:0] cnt_q,   cnt_d;
    logic [T_W-1:0]       t_q,     t_d;
    logic                 sync_q,  sync_d;
    logic                 err_q,   err_d;

    logic nmi_pend;
    logic irq_pend;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        err_d   = 1'b0;
        if (bus.rdy) begin
            unique case (state_q)
                RSTSEQ: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + RST_CNT_W'(1);
                    end
                end
                FETCH: begin
                    state_d = EXEC;
                    t_d     = T_W'(1);
                end
                EXEC: begin
                    if (bus.last_cycle) begin
                        state_d = FETCH;
                        t_d     = '0;
                    end else if (t_q == T_LAST) begin
                        // Decoder never flagged the end: force a refetch and report it.
                        state_d = FETCH;
                        t_d     = '0;
                        err_d   = 1'b1;
                    end else begin
                        t_d = t_q + T_W'(1);
                    end
                end
                default: begin
                    state_d = RSTSEQ;
                    cnt_d   = '0;
                    t_d     = '0;
                end
            endcase
        end
        sync_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RSTSEQ;
            cnt_q   <= '0;
            t_q     <= '0;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            sync_q  <= sync_d;
            err_q   <= err_d;
        end
    end

`ifdef CYCLE_SEQ_INT_EN
    int_ctl u_int_ctl (
        .clk      (clk),
        .rst      (rst),
        .rdy      (bus.rdy),
        .fetch    (sync_q),
        .nmi_n    (bus.nmi_n),
        .irq_n    (bus.irq_n),
        .i_flag   (bus.i_flag),
        .nmi_pend (nmi_pend),
        .irq_pend (irq_pend)
    );
`else
    logic unused_int_pins;
    assign unused_int_pins = ^{bus.nmi_n, bus.irq_n, bus.i_flag};
    assign nmi_pend        = 1'b0;
    assign irq_pend        = 1'b0;
`endif

    assign bus.sync       = sync_q;
    assign bus.t_state    = t_q;
    assign bus.seq_err    = err_q;
    assign bus.ir_load    = sync_q && bus.rdy;
    assign bus.int_inject = sync_q && (nmi_pend || irq_pend);
    assign bus.nmi_sel    = sync_q && nmi_pend;
    assign bus.pc_inc     = bus.ir_load && !bus.int_inject;
endmodule

// File: tb/tb_cycle_seq.sv
// Bench for cycle_seq: directed scenarios plus randomized pins against a cycle-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_cycle_seq;
    localparam int RC   = 7;
    localparam int MAXT = 7;
`ifdef CYCLE_SEQ_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cycle_seq_if bus_if ();

    cycle_seq #(.RESET_CYCLES(RC), .MAX_T(MAXT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: cycles left in the reset sequence, instruction step (0 = fetch), NMI latch.
    int m_rst_left = RC;
    int m_step     = 0;
    bit m_nmi_pend = 1'b0;
    bit m_nmi_prev = 1'b1;
    bit m_err      = 1'b0;

    always @(posedge clk) begin
        bit fell;
        if (rst) begin
            m_rst_left = RC;
            m_step     = 0;
            m_nmi_pend = 1'b0;
            m_nmi_prev = 1'b1;
            m_err      = 1'b0;
        end else begin
            fell       = m_nmi_prev && !bus_if.nmi_n;
            m_nmi_prev = bus_if.nmi_n;
            m_err      = 1'b0;
            if (bus_if.rdy) begin
                if (m_rst_left > 0) begin
                    m_rst_left--;
                end else if (m_step == 0) begin
                    m_nmi_pend = 1'b0;
                    m_step     = 1;
                end else if (bus_if.last_cycle) begin
                    m_step = 0;
                end else if (m_step == MAXT) begin
                    m_step = 0;
                    m_err  = 1'b1;
                end else begin
                    m_step++;
                end
            end
            if (fell) m_nmi_pend = 1'b1;
        end
    end

    always @(negedge clk) begin
        bit e_fetch, e_nmi, e_irq, e_inj, e_ld;
        int e_t;
        if (rst) begin
            e_fetch = 0; e_nmi = 0; e_irq = 0; e_t = 0;
        end else begin
            e_fetch = (m_rst_left == 0) && (m_step == 0);
            e_nmi   = INT_EN && m_nmi_pend;
            e_irq   = INT_EN && !bus_if.irq_n && !bus_if.i_flag;
            e_t     = (m_rst_left > 0) ? 0 : m_step;
        end
        e_inj = e_fetch && (e_nmi || e_irq);
        e_ld  = e_fetch && bus_if.rdy && !rst;
        chk("sync",       8'(bus_if.sync),       8'(e_fetch));
        chk("t_state",    8'(bus_if.t_state),    8'(e_t));
        chk("ir_load",    8'(bus_if.ir_load),    8'(e_ld));
        chk("pc_inc",     8'(bus_if.pc_inc),     8'(e_ld && !e_inj));
        chk("int_inject", 8'(bus_if.int_inject), 8'(e_inj));
        chk("nmi_sel",    8'(bus_if.nmi_sel),    8'(e_fetch && e_nmi));
        chk("seq_err",    8'(bus_if.seq_err),    8'(!rst && m_err));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_to_fetch(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus_if.sync) break;
        end
    endtask

    initial begin
        int n;
        bus_if.rdy        = 1'b1;
        bus_if.last_cycle = 1'b0;
        bus_if.nmi_n      = 1'b1;
        bus_if.irq_n      = 1'b1;
        bus_if.i_flag     = 1'b1;

        @(negedge clk);
        chk("rst_sync", 8'(bus_if.sync), 8'd0);
        chk("rst_t",    8'(bus_if.t_state), 8'd0);
        repeat (3) tick();
        rst = 1'b0;

        // Reset sequence length and a three-cycle instruction.
        count_to_fetch(n);
        chk("reset_len", 8'(n), 8'd7);
        chk("first_fetch_t", 8'(bus_if.t_state), 8'd0);
        tick();
        @(negedge clk); chk("t1", 8'(bus_if.t_state), 8'd1);
        tick(); bus_if.last_cycle = 1'b1;
        @(negedge clk); chk("t2", 8'(bus_if.t_state), 8'd2);

        // Three stalled cycles in FETCH.
        tick(); bus_if.last_cycle = 1'b0; bus_if.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_sync", 8'(bus_if.sync), 8'd1);
            chk("stall_ld",   8'(bus_if.ir_load), 8'd0);
            chk("stall_t",    8'(bus_if.t_state), 8'd0);
            if (i < 2) tick();
        end
        tick(); bus_if.rdy = 1'b1;
        @(negedge clk); chk("unstall_ld", 8'(bus_if.ir_load), 8'd1);
        tick();
        @(negedge clk); chk("unstall_t", 8'(bus_if.t_state), 8'd1);

        // Runaway instruction hits MAX_T.
        for (int i = 0; i < 12; i++) begin
            if (bus_if.t_state == 3'd7) break;
            tick();
            @(negedge clk);
        end
        chk("t_max", 8'(bus_if.t_state), 8'(MAXT));
        tick();
        @(negedge clk);
        chk("ovf_sync", 8'(bus_if.sync), 8'd1);
        chk("ovf_err",  8'(bus_if.seq_err), 8'd1);
        tick();
        @(negedge clk);
        chk("ovf_err_pulse", 8'(bus_if.seq_err), 8'd0);
        chk("ovf_next_t",    8'(bus_if.t_state), 8'd1);

        // NMI edge during EXEC with IRQ also pending.
        tick();
        bus_if.nmi_n = 1'b0; bus_if.irq_n = 1'b0; bus_if.i_flag = 1'b0; bus_if.last_cycle = 1'b1;
        @(negedge clk); chk("nmi_exec_t", 8'(bus_if.t_state), 8'd2);
        tick();
        @(negedge clk);
        chk("nmi_inj", 8'(bus_if.int_inject), 8'(INT_EN));
        chk("nmi_sel", 8'(bus_if.nmi_sel),    8'(INT_EN));
        chk("nmi_pc",  8'(bus_if.pc_inc),     8'(!INT_EN));
        tick();
        @(negedge clk); chk("inj_exec", 8'(bus_if.int_inject), 8'd0);
        tick();
        @(negedge clk);
        chk("irq_inj", 8'(bus_if.int_inject), 8'(INT_EN));
        chk("irq_sel", 8'(bus_if.nmi_sel),    8'd0);

        // Masked IRQ, then reset mid-instruction.
        tick(); bus_if.i_flag = 1'b1; bus_if.nmi_n = 1'b1;
        tick();
        @(negedge clk);
        chk("masked_sync", 8'(bus_if.sync), 8'd1);
        chk("masked_inj",  8'(bus_if.int_inject), 8'd0);
        tick(); bus_if.last_cycle = 1'b0;
        tick();
        tick();
        @(negedge clk); chk("pre_rst_t", 8'(bus_if.t_state), 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_t",    8'(bus_if.t_state), 8'd0);
        chk("async_rst_sync", 8'(bus_if.sync), 8'd0);
        tick(); rst = 1'b0;
        bus_if.irq_n = 1'b1;
        count_to_fetch(n);
        chk("reset_len2", 8'(n), 8'd7);

        // Randomized pins; the per-cycle compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 199) == 0) rst = 1'b1;
            bus_if.rdy        = ($urandom_range(0, 3) != 0);
            bus_if.last_cycle = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 7) == 0) bus_if.nmi_n = ~bus_if.nmi_n;
            if ($urandom_range(0, 5) == 0) bus_if.irq_n = ~bus_if.irq_n;
            if ($urandom_range(0, 9) == 0) bus_if.i_flag = ~bus_if.i_flag;
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
